// File: rtl/maindec_pkg.sv
// Shared encodings for the multicycle main decoder and its ALU decoder.
package maindec_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    ADDIEX  = 4'd8,
    ADDIWB  = 4'd9,
    BRANCH  = 4'd10,
    JUMP    = 4'd11,
    HALT    = 4'd12
  } statetype;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0001;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_ADDI  = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_J     = 4'b0101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/maindec.sv
// Multicycle main control FSM: sequences each instruction and drives the
// datapath enables, mux selects and the aluop code for aludec.
//
// state   | meaning
// FETCH   | read instruction at PC, PC += 2 (stalls on mem_ready)
// DECODE  | read registers, branch target into ALUOut, dispatch on op
// MEMADR  | compute lw/sw effective address
// MEMRD   | read data memory (stalls on mem_ready)
// MEMWB   | write MDR to rt
// MEMWR   | write data memory (stalls on mem_ready)
// EXECUTE | R-type ALU operation
// ALUWB   | write ALUOut to rd
// ADDIEX  | rs + sign-ext imm
// ADDIWB  | write ALUOut to rt
// BRANCH  | compare rs/rt, conditional PC load from ALUOut
// JUMP    | unconditional PC load from jump target
// HALT    | illegal opcode trap, sticky until reset
module maindec
  import maindec_pkg::*;
#(
  parameter int n = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [n-1:n-4] op,
  input  logic           mem_ready,
  output logic           pcwrite,
  output logic           branch,
  output logic           iord,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regwrite,
  output logic           regdst,
  output logic           memtoreg,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic [1:0]     aluop,
  output logic           halt,
  output logic [3:0]     state
);

  statetype state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_RTYPE:     state_d = EXECUTE;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_ADDI:      state_d = ADDIEX;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          default:      state_d = HALT;
        endcase
      end
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (mem_ready) state_d = MEMWB;
      MEMWB:   state_d = FETCH;
      MEMWR:   if (mem_ready) state_d = FETCH;
      EXECUTE: state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      BRANCH:  state_d = FETCH;
      JUMP:    state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    halt     = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:  regwrite = 1'b1;
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
        pcsrc   = 2'b01;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      HALT:    halt = 1'b1;
      default: ;
    endcase
    // The FETCH enables follow mem_ready, so gate them while reset is held.
    if (!reset) begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      branch   = 1'b0;
    end
  end

  assign state = state_q;

endmodule
